// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with occupancy thresholds, sticky error flags
// and selectable registered or first-word-fall-through read.
module sync_fifo_param #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT = 0,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd_en,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [CW-1:0]     count,
  input  logic              clr_err,
  output logic              overflow,
  output logic              underflow
);
  localparam int PW = $clog2(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic rd_acc, wr_acc;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign almost_full = count >= CW'(AF_LEVEL);
  assign almost_empty = count <= CW'(AE_LEVEL);
  assign rd_acc = rd_en && !empty;
  // a write into a full FIFO still lands when the head leaves in the same cycle
  assign wr_acc = wr_en && (!full || rd_acc);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr == PW'(DEPTH - 1) ? '0 : wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr == PW'(DEPTH - 1) ? '0 : rd_ptr + 1'b1;
      count <= count + CW'(wr_acc && !rd_acc) - CW'(rd_acc && !wr_acc);
      overflow <= (wr_en && !wr_acc) || (overflow && !clr_err);
      underflow <= (rd_en && empty) || (underflow && !clr_err);
    end
  end
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= data_in;
  end
  generate
    if (FWFT != 0) begin : g_fwft
      assign data_out = empty ? '0 : mem[rd_ptr];
      assign rd_valid = !empty;
    end else begin : g_reg
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          data_out <= '0;
          rd_valid <= 1'b0;
        end else begin
          rd_valid <= rd_acc;
          if (rd_acc) data_out <= mem[rd_ptr];
        end
      end
    end
  endgenerate
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: queue-model checked bench for a registered-read FIFO (DEPTH=16)
// and a first-word-fall-through FIFO (DEPTH=5).
module tb_sync_fifo_param;
  logic clk = 1'b0, rst_n = 1'b0;
  logic wa = 0, ra = 0, ca = 0, wb = 0, rb = 0, cb = 0;
  logic [7:0] da = 0, db = 0;
  logic [7:0] a_dout, b_dout;
  logic a_rv, a_full, a_empty, a_af, a_ae, a_ovf, a_udf;
  logic b_rv, b_full, b_empty, b_af, b_ae, b_ovf, b_udf;
  logic [4:0] a_cnt;
  logic [2:0] b_cnt;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  sync_fifo_param #(.DATA_W(8), .DEPTH(16), .FWFT(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .wr_en(wa), .data_in(da), .rd_en(ra), .data_out(a_dout),
    .rd_valid(a_rv), .full(a_full), .empty(a_empty), .almost_full(a_af), .almost_empty(a_ae),
    .count(a_cnt), .clr_err(ca), .overflow(a_ovf), .underflow(a_udf));

  sync_fifo_param #(.DATA_W(8), .DEPTH(5), .FWFT(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .wr_en(wb), .data_in(db), .rd_en(rb), .data_out(b_dout),
    .rd_valid(b_rv), .full(b_full), .empty(b_empty), .almost_full(b_af), .almost_empty(b_ae),
    .count(b_cnt), .clr_err(cb), .overflow(b_ovf), .underflow(b_udf));

  function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endfunction

  // Reference model: queues of stored words plus the error flags and read register.
  logic [7:0] qa[$], qb[$];
  logic ma_ovf, ma_udf, ma_rv, mb_ovf, mb_udf;
  logic [7:0] ma_dout;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qa.delete(); qb.delete();
      ma_ovf = 0; ma_udf = 0; ma_rv = 0; ma_dout = 0; mb_ovf = 0; mb_udf = 0;
    end else begin
      automatic bit rda = ra && qa.size() > 0;
      automatic bit wra = wa && (qa.size() < 16 || rda);
      automatic bit rdb = rb && qb.size() > 0;
      automatic bit wrb = wb && (qb.size() < 5 || rdb);
      ma_ovf = (wa && !wra) ? 1'b1 : ca ? 1'b0 : ma_ovf;
      ma_udf = (ra && qa.size() == 0) ? 1'b1 : ca ? 1'b0 : ma_udf;
      mb_ovf = (wb && !wrb) ? 1'b1 : cb ? 1'b0 : mb_ovf;
      mb_udf = (rb && qb.size() == 0) ? 1'b1 : cb ? 1'b0 : mb_udf;
      ma_rv = rda;
      if (rda) ma_dout = qa.pop_front();
      if (wra) qa.push_back(da);
      if (rdb) void'(qb.pop_front());
      if (wrb) qb.push_back(db);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("a_count", a_cnt, qa.size());
      chk("a_empty", a_empty, qa.size() == 0);
      chk("a_full", a_full, qa.size() == 16);
      chk("a_af", a_af, qa.size() >= 14);
      chk("a_ae", a_ae, qa.size() <= 2);
      chk("a_ovf", a_ovf, ma_ovf);
      chk("a_udf", a_udf, ma_udf);
      chk("a_rv", a_rv, ma_rv);
      chk("a_dout", a_dout, ma_dout);
      chk("b_count", b_cnt, qb.size());
      chk("b_empty", b_empty, qb.size() == 0);
      chk("b_full", b_full, qb.size() == 5);
      chk("b_af", b_af, qb.size() >= 3);
      chk("b_ae", b_ae, qb.size() <= 2);
      chk("b_ovf", b_ovf, mb_ovf);
      chk("b_udf", b_udf, mb_udf);
      chk("b_rv", b_rv, qb.size() != 0);
      chk("b_dout", b_dout, qb.size() != 0 ? qb[0] : 8'h00);
    end
  end

  task automatic sa(input logic w, input logic [7:0] d, input logic r, input logic c);
    wa = w; da = d; ra = r; ca = c;
    @(posedge clk); #2;
    wa = 0; ra = 0; ca = 0;
  endtask

  task automatic sb(input logic w, input logic [7:0] d, input logic r);
    wb = w; db = d; rb = r;
    @(posedge clk); #2;
    wb = 0; rb = 0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2;
    chk("rst_empty", a_empty, 1);
    chk("rst_ae", a_ae, 1);
    chk("rst_count", a_cnt, 0);
    chk("rst_full", a_full, 0);
    chk("rst_af", a_af, 0);
    chk("rst_ovf", a_ovf, 0);
    chk("rst_udf", a_udf, 0);
    chk("rst_dout", a_dout, 0);
    chk("rst_rv", a_rv, 0);
    chk("rst_b_empty", b_empty, 1);
    rst_n = 1;
    sa(0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      sa(1, 8'(i), 0, 0);
      chk("fill_count", a_cnt, i + 1);
      chk("fill_af", a_af, (i + 1) >= 14);
      chk("fill_full", a_full, i == 15);
    end
    sa(1, 8'hEE, 0, 0);
    chk("ovf_set", a_ovf, 1);
    chk("ovf_count", a_cnt, 16);
    sa(0, 0, 0, 1);
    chk("ovf_clr", a_ovf, 0);
    sa(1, 8'h55, 1, 0);
    chk("sim_full_count", a_cnt, 16);
    chk("sim_full_ovf", a_ovf, 0);
    chk("sim_full_dout", a_dout, 8'h00);
    chk("sim_full_rv", a_rv, 1);
    for (int i = 1; i <= 16; i++) begin
      sa(0, 0, 1, 0);
      chk("drain_rv", a_rv, 1);
      chk("drain_dout", a_dout, i == 16 ? 8'h55 : 8'(i));
    end
    chk("drain_empty", a_empty, 1);
    sa(0, 0, 0, 0);
    chk("idle_rv", a_rv, 0);
    chk("idle_hold", a_dout, 8'h55);
    sa(1, 8'h77, 1, 0);
    chk("sim_empty_count", a_cnt, 1);
    chk("sim_empty_udf", a_udf, 1);
    chk("sim_empty_rv", a_rv, 0);
    sa(0, 0, 0, 1);
    chk("udf_clr", a_udf, 0);
    sa(0, 0, 1, 0);
    chk("read_77", a_dout, 8'h77);
    sa(0, 0, 1, 1);
    chk("udf_set_wins", a_udf, 1);
    sa(0, 0, 0, 1);
    for (int i = 0; i < 7; i++) sa(1, 8'(8'h10 + i), 0, 0);
    chk("pre_rst_count", a_cnt, 7);
    rst_n = 0;
    #1;
    chk("async_rst_count", a_cnt, 0);
    chk("async_rst_empty", a_empty, 1);
    @(posedge clk); #2;
    rst_n = 1;
    sa(1, 8'h3C, 0, 0);
    sa(0, 0, 1, 0);
    chk("post_rst_data", a_dout, 8'h3C);
    chk("post_rst_empty", a_empty, 1);
    for (int i = 1; i <= 3; i++) sb(1, 8'(i), 0);
    chk("b_pre_count", b_cnt, 3);
    chk("b_head", b_dout, 8'h01);
    for (int i = 0; i < 3; i++) sb(0, 0, 1);
    chk("b_drained", b_empty, 1);
    chk("b_empty_dout", b_dout, 8'h00);
    for (int i = 0; i < 5; i++) begin
      sb(1, 8'(8'hA0 + i), 0);
      chk("b_wrap_head", b_dout, 8'hA0);
    end
    chk("b_wrap_full", b_full, 1);
    chk("b_wrap_count", b_cnt, 5);
    for (int i = 1; i <= 5; i++) begin
      sb(0, 0, 1);
      chk("b_pop", b_dout, i == 5 ? 8'h00 : 8'(8'hA0 + i));
    end
    chk("b_final_empty", b_empty, 1);
    chk("b_final_rv", b_rv, 0);
    chk("b_no_err", {b_ovf, b_udf}, 2'b00);
    sa(0, 0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
